th_fetch_resp: RTL and testbench
================================

Name: th_fetch_resp

Overview:
- Responder (cache side) for the fetch unit's lookup/ack interface. It answers each `if_lookup` by checking the two tags the fetch unit supplies. It then returns the instruction word with hit/packed flags.
- On a miss it fills the LRU bank from instruction memory. It then issues an `is_update` with the new tag, LRU state and bank so the fetch unit can refresh its tag registers and retry.
- Sits between the fetch/branch unit and the instruction memory port.

Parameters:
- TAG_W, 7, tag width; tag is `pc[PC_W-1:OFS_W]`.
- OFS_W, 3, word-offset width; line is 2**OFS_W words.
- PC_W, 10, PC width; must equal TAG_W+OFS_W.
- DATA_W, 32, instruction word width.

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, synchronous, active-low reset.
- enable_i, in, 1, global stall; when 0, no lookup is accepted and the FSM holds. A transfer already handshaking on `mem_ack_i` still completes.
- if_lookup_i, in, 1, lookup request from the fetch unit.
- if_pc_i, in, PC_W, word address of the lookup.
- if_tag0_i / if_tag1_i, in, TAG_W each, tags currently held for bank 0 / bank 1.
- if_vld0_i / if_vld1_i, in, 1 each, tag-valid flags for bank 0 / bank 1.
- if_ack_o, out, 1, lookup accepted; single-cycle pulse.
- if_hit_o, out, 1, qualifies `if_ack_o`: 1 means `if_instr_o` is valid.
- if_packed_o, out, 1, `if_instr_o[DATA_W-1]`; marks a packed instruction pair.
- if_instr_o, out, DATA_W, instruction word.
- is_busy_o, out, 1, fill in progress; no lookups accepted.
- is_update_o, out, 1, single-cycle pulse when a fill completes.
- is_newtag_o, out, TAG_W, tag of the filled line.
- is_lru_no, out, 1, active-low LRU indicator; 0 means bank 1 is LRU.
- is_bank_o, out, 1, bank that was filled.
- mem_req_o, out, 1, memory read request.
- mem_addr_o, out, PC_W, memory word address.
- mem_ack_i, in, 1, memory returns `mem_data_i` this cycle.
- mem_data_i, in, DATA_W, memory read data.

Behaviour:
- Reset values (`reset_n`=0 at a clock edge): all outputs 0, except `is_lru_no`=1 (bank 0 is LRU). FSM goes to IDLE, fill counter 0, `mem_req_o` drops immediately. Line RAM contents are not cleared.
- Storage: two banks of 2**OFS_W × DATA_W registers, indexed `{bank, offset}`. The fetch unit owns tag/valid state; this block keeps no tags.
- FSM states: IDLE, RESP, FILL, UPDATE.
- IDLE: when `if_lookup_i & enable_i & ~is_busy_o`:
  - hit0 = `if_vld0_i & (if_tag0_i == pc[PC_W-1:OFS_W])`; hit1 likewise for bank 1.
  - If both match, bank 0 wins.
  - Latch pc and go to RESP.
- RESP (exactly 1 cycle after acceptance):
  - `if_ack_o`=1 and `if_hit_o` = hit0|hit1.
  - On a hit: `if_instr_o` = `bank[hitbank][pc offset]` and `if_packed_o` = its MSB. The LRU bit is set to the non-hit bank. Return to IDLE, so back-to-back hits run at one lookup every 2 cycles.
  - On a miss: `if_instr_o` and `if_packed_o` are 0. Victim = current LRU bank. `is_busy_o` goes to 1 from this edge. Go to FILL.
- FILL:
  - `mem_req_o`=1 with `mem_addr_o` = `{tag, cnt}`, where cnt runs 0..2**OFS_W-1.
  - Each `mem_ack_i` writes `mem_data_i` to `bank[victim][cnt]` and increments cnt.
  - After the last word, `mem_req_o` drops the next cycle and the FSM goes to UPDATE.
  - Memory latency is unbounded; there is no timeout.
- UPDATE (1 cycle):
  - `is_update_o`=1, `is_newtag_o` = latched tag, `is_bank_o` = victim.
  - The LRU bit flips to the other bank.
  - `is_busy_o` drops at the end of the cycle; return to IDLE.
  - The fetch unit re-issues the lookup, which then hits.
- Registered outputs hold between updates: `is_newtag_o`, `is_bank_o`, and `is_lru_no` (= ~lru, registered).
- Lookups in RESP/FILL/UPDATE are not acked. The fetch unit must hold `if_lookup_i` until `if_ack_o`.
- Lookup asserted in the same cycle as `is_update_o`: not accepted; it is accepted the next cycle.
- `enable_i`=0:
  - In IDLE: no acceptance.
  - In FILL: `mem_req_o` is held, but an in-flight `mem_ack_i` word is still written and counted.
  - In RESP/UPDATE: the state and its pulse stay asserted until `enable_i` returns.
- `mem_ack_i` outside FILL is ignored.
- Reset mid-fill: the fill is aborted with no `is_update_o`. The partially written bank is never reported valid, because no update is issued.
- Offset counter wraps naturally at 2**OFS_W, which terminates the fill.

Test Plan:
- Reset, then lookup pc=0x00A with vld0=1, tag0=0x01 → `if_ack_o`=1, `if_hit_o`=1 one cycle later. `if_instr_o` = bank0 word 2, written by a prior fill.
- Lookup pc=0x158 with vld0=vld1=0 → ack with hit=0. Then 8 `mem_req` cycles at addr 0x158..0x15F. Then `is_update_o` with newtag=0x2B, bank=0, `is_lru_no`=0. A retry with tag0=0x2B, vld0=1 hits, returning the word from 0x158.
- Second miss (tag 0x3C) → fill goes to bank 1. `is_update_o` shows bank=1 and `is_lru_no`=1.
- Memory ack with gaps (ack every 3rd cycle) during a fill → all 8 words are stored in order and `is_busy_o` is 1 throughout. A lookup held during the fill is acked only after UPDATE.
- Both tags equal and valid → bank 0 data is returned and LRU becomes bank 1. A word with MSB=1 → `if_packed_o`=1.
- `reset_n` low after 4 fill words → `mem_req_o`=0, no `is_update_o`, IDLE. The next lookup is accepted normally.

Source files
------------

// File: rtl/th_fetch_resp.sv
// Fetch-side responder: answers lookups from a two-bank line store and refills
// the LRU bank from instruction memory on a miss, then reports the new tag.
module th_fetch_resp #(
  parameter int TAG_W  = 7,
  parameter int OFS_W  = 3,
  parameter int PC_W   = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              if_lookup_i,
  input  logic [PC_W-1:0]   if_pc_i,
  input  logic [TAG_W-1:0]  if_tag0_i,
  input  logic [TAG_W-1:0]  if_tag1_i,
  input  logic              if_vld0_i,
  input  logic              if_vld1_i,
  output logic              if_ack_o,
  output logic              if_hit_o,
  output logic              if_packed_o,
  output logic [DATA_W-1:0] if_instr_o,
  output logic              is_busy_o,
  output logic              is_update_o,
  output logic [TAG_W-1:0]  is_newtag_o,
  output logic              is_lru_no,
  output logic              is_bank_o,
  output logic              mem_req_o,
  output logic [PC_W-1:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int LINE_WORDS = 2 ** OFS_W;

  typedef enum logic [1:0] {IDLE, RESP, FILL, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [OFS_W-1:0]    cnt_q, cnt_d;
  logic                lru_q, lru_d;
  logic                victim_q, victim_d;
  logic                ack_q, ack_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                busy_q, busy_d;
  logic                update_q, update_d;
  logic [TAG_W-1:0]    newtag_q, newtag_d;
  logic                bank_q, bank_d;
  logic                req_q, req_d;

  logic [DATA_W-1:0]   ram_q [2*LINE_WORDS];
  logic                ram_we;
  logic [OFS_W:0]      rd_idx;
  logic [OFS_W:0]      wr_idx;

  logic                hit0;
  logic                hit1;
  logic                lookup_go;

  // Handshake: the fetch unit holds if_lookup_i until if_ack_o, a one-cycle
  // pulse the cycle after acceptance; mem_req_o stays high, with mem_addr_o
  // stable, until mem_ack_i is seen for that word.
  assign hit0      = if_vld0_i && (if_tag0_i == if_pc_i[PC_W-1:OFS_W]);
  assign hit1      = if_vld1_i && (if_tag1_i == if_pc_i[PC_W-1:OFS_W]);
  assign lookup_go = if_lookup_i && enable_i && !busy_q;
  // Bank 0 wins when both tags match.
  assign rd_idx    = {~hit0, if_pc_i[OFS_W-1:0]};
  assign wr_idx    = {victim_q, cnt_q};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    lru_d    = lru_q;
    victim_d = victim_q;
    ack_d    = ack_q;
    hit_d    = hit_q;
    instr_d  = instr_q;
    busy_d   = busy_q;
    update_d = update_q;
    newtag_d = newtag_q;
    bank_d   = bank_q;
    req_d    = req_q;
    ram_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup_go) begin
          state_d = RESP;
          pc_d    = if_pc_i;
          ack_d   = 1'b1;
          hit_d   = hit0 || hit1;
          if (hit0 || hit1) begin
            instr_d = ram_q[rd_idx];
            lru_d   = hit0;
          end else begin
            instr_d  = '0;
            busy_d   = 1'b1;
            victim_d = lru_q;
          end
        end
      end
      RESP: begin
        if (enable_i) begin
          ack_d = 1'b0;
          hit_d = 1'b0;
          if (hit_q) begin
            state_d = IDLE;
          end else begin
            state_d = FILL;
            req_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      FILL: begin
        // A returning word is taken even while stalled so memory never loses data.
        if (mem_ack_i) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (&cnt_q) begin
            req_d    = 1'b0;
            update_d = 1'b1;
            newtag_d = pc_q[PC_W-1:OFS_W];
            bank_d   = victim_q;
            lru_d    = ~victim_q;
            state_d  = UPDATE;
          end
        end
      end
      UPDATE: begin
        if (enable_i) begin
          update_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      lru_q    <= 1'b0;
      victim_q <= 1'b0;
      ack_q    <= 1'b0;
      hit_q    <= 1'b0;
      instr_q  <= '0;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
      newtag_q <= '0;
      bank_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      lru_q    <= lru_d;
      victim_q <= victim_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      instr_q  <= instr_d;
      busy_q   <= busy_d;
      update_q <= update_d;
      newtag_q <= newtag_d;
      bank_q   <= bank_d;
      req_q    <= req_d;
    end
  end

  // Line storage is deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (reset_n && ram_we) begin
      ram_q[wr_idx] <= mem_data_i;
    end
  end

  assign if_ack_o    = ack_q;
  assign if_hit_o    = hit_q;
  assign if_instr_o  = instr_q;
  assign if_packed_o = instr_q[DATA_W-1];
  assign is_busy_o   = busy_q;
  assign is_update_o = update_q;
  assign is_newtag_o = newtag_q;
  assign is_lru_no   = ~lru_q;
  assign is_bank_o   = bank_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = {pc_q[PC_W-1:OFS_W], cnt_q};

endmodule

// File: tb/tb_th_fetch_resp.sv
// Bench for th_fetch_resp: directed lookups against a memory responder, with a
// transaction-level cache model checked on every negative clock edge.
module tb_th_fetch_resp;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_i = 1'b1;
  logic        if_lookup_i = 1'b0;
  logic [9:0]  if_pc_i = '0;
  logic [6:0]  if_tag0_i = '0;
  logic [6:0]  if_tag1_i = '0;
  logic        if_vld0_i = 1'b0;
  logic        if_vld1_i = 1'b0;
  logic        if_ack_o, if_hit_o, if_packed_o;
  logic [31:0] if_instr_o;
  logic        is_busy_o, is_update_o, is_lru_no, is_bank_o;
  logic [6:0]  is_newtag_o;
  logic        mem_req_o;
  logic [9:0]  mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;

  th_fetch_resp dut (
    .clock(clock), .reset_n(reset_n), .enable_i(enable_i),
    .if_lookup_i(if_lookup_i), .if_pc_i(if_pc_i),
    .if_tag0_i(if_tag0_i), .if_tag1_i(if_tag1_i),
    .if_vld0_i(if_vld0_i), .if_vld1_i(if_vld1_i),
    .if_ack_o(if_ack_o), .if_hit_o(if_hit_o), .if_packed_o(if_packed_o),
    .if_instr_o(if_instr_o), .is_busy_o(is_busy_o), .is_update_o(is_update_o),
    .is_newtag_o(is_newtag_o), .is_lru_no(is_lru_no), .is_bank_o(is_bank_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Instruction memory contents: MSB (packed flag) follows the address LSB.
  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {a[0], 7'h00, 8'hAB, 6'h00, a};
  endfunction

  // ---------------- memory responder ----------------
  int ack_gap = 0;
  int ack_limit = 8;
  int gap_cnt = 0;
  int given = 0;

  always @(posedge clock) begin
    #1;
    if (mem_req_o && reset_n && given < ack_limit) begin
      if (gap_cnt >= ack_gap) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o);
        gap_cnt    = 0;
        given++;
      end else begin
        mem_ack_i = 1'b0;
        gap_cnt++;
      end
    end else begin
      mem_ack_i = 1'b0;
      if (!mem_req_o) begin
        given   = 0;
        gap_cnt = 0;
      end
    end
  end

  // ---------------- model + scoreboard ----------------
  // Lookup expectations are queued at acknowledge time from the held request.
  logic [6:0]  m_line [2] = '{7'h00, 7'h00};
  logic        m_lru = 1'b0;
  logic        m_filling = 1'b0;
  logic        m_victim = 1'b0;
  logic [6:0]  m_tag = '0;
  int          m_cnt = 0;
  int          upd_cyc = 0;
  logic [31:0] exp_q[$];
  logic        c_h0, c_h1, c_hb, c_exp_req, c_exp_upd;
  logic [6:0]  c_tag;
  logic [31:0] c_exp;

  always @(negedge clock) begin
    if (!reset_n) begin
      m_filling = 1'b0;
      m_cnt     = 0;
      m_lru     = 1'b0;
    end else begin
      c_exp_req = m_filling && (m_cnt < 8);
      check("mem_req", mem_req_o, c_exp_req);
      if (c_exp_req) check("mem_addr", mem_addr_o, int'(m_tag) * 8 + m_cnt);
      if (m_filling) check("busy_in_fill", is_busy_o, 1);
      else if (!if_ack_o) check("busy_idle", is_busy_o, 0);
      check("ack_in_fill", if_ack_o & m_filling, 0);
      c_exp_upd = m_filling && (m_cnt == 8);
      check("is_update", is_update_o, c_exp_upd);
      if (c_exp_upd) begin
        check("upd_newtag", is_newtag_o, m_tag);
        check("upd_bank", is_bank_o, m_victim);
        check("upd_lru_no", is_lru_no, m_victim);
        m_line[m_victim] = m_tag;
        m_lru            = ~m_victim;
        m_filling        = 1'b0;
        upd_cyc          = cyc;
      end
      if (if_ack_o) begin
        c_tag = if_pc_i[9:3];
        c_h0  = if_vld0_i && (if_tag0_i == c_tag);
        c_h1  = if_vld1_i && (if_tag1_i == c_tag);
        if (c_h0 || c_h1) begin
          c_hb = c_h0 ? 1'b0 : 1'b1;
          exp_q.push_back(mem_word({m_line[c_hb], if_pc_i[2:0]}));
          m_lru = ~c_hb;
        end else begin
          exp_q.push_back(32'h0);
          m_filling = 1'b1;
          m_tag     = c_tag;
          m_victim  = m_lru;
          m_cnt     = 0;
        end
        check("ack_hit", if_hit_o, c_h0 || c_h1);
        c_exp = exp_q.pop_front();
        check("ack_instr", if_instr_o, c_exp);
        check("ack_packed", if_packed_o, c_exp[31]);
      end
      if (m_filling && mem_req_o && mem_ack_i && m_cnt < 8) m_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  int ack_cyc = 0;

  task automatic do_lookup(input string name, input logic [9:0] pc,
                           input logic [6:0] t0, input logic v0,
                           input logic [6:0] t1, input logic v1, input int stall,
                           output logic hit, output logic [31:0] instr,
                           output logic pk, output int lat);
    int start;
    bit got;
    @(posedge clock); #1;
    if_lookup_i = 1'b1;
    if_pc_i = pc;
    if_tag0_i = t0; if_vld0_i = v0;
    if_tag1_i = t1; if_vld1_i = v1;
    if (stall > 0) begin
      enable_i = 1'b0;
      repeat (stall) begin
        @(negedge clock);
        check({name, "_stall_no_ack"}, if_ack_o, 0);
      end
      @(posedge clock); #1;
      enable_i = 1'b1;
    end
    start = cyc;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clock);
      if (if_ack_o) got = 1'b1;
    end
    check({name, "_ack_seen"}, got, 1);
    hit = if_hit_o;
    instr = if_instr_o;
    pk = if_packed_o;
    lat = cyc - start;
    ack_cyc = cyc;
    if_lookup_i = 1'b0;
  endtask

  task automatic wait_update(input string name, input logic [6:0] tag,
                             input logic bank, input logic lru_no);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clock);
      if (is_update_o) seen = 1'b1;
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_newtag"}, is_newtag_o, tag);
      check({name, "_bank"}, is_bank_o, bank);
      check({name, "_lru_no"}, is_lru_no, lru_no);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic        r_hit, r_pk;
  logic [31:0] r_instr;
  int          r_lat;
  int          n_upd;
  bit          reached;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ack", if_ack_o, 0);
    check("rst_busy", is_busy_o, 0);
    check("rst_update", is_update_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_lru_no", is_lru_no, 1);
    check("rst_instr", if_instr_o, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // First miss fills bank 0 with line 0x158.
    do_lookup("miss158", 10'h158, 7'h00, 0, 7'h00, 0, 0, r_hit, r_instr, r_pk, r_lat);
    check("miss158_hit", r_hit, 0);
    check("miss158_lat", r_lat, 1);
    wait_update("upd2b", 7'h2B, 1'b0, 1'b0);
    do_lookup("hit158", 10'h158, 7'h2B, 1, 7'h00, 0, 0, r_hit, r_instr, r_pk, r_lat);
    check("hit158_hit", r_hit, 1);
    check("hit158_instr", r_instr, 32'h00AB0158);
    check("hit158_lat", r_lat, 1);

    // Second miss goes to bank 1.
    do_lookup("miss1e5", 10'h1E5, 7'h2B, 1, 7'h00, 0, 0, r_hit, r_instr, r_pk, r_lat);
    check("miss1e5_hit", r_hit, 0);
    wait_update("upd3c", 7'h3C, 1'b1, 1'b1);
    do_lookup("hit1e5", 10'h1E5, 7'h2B, 1, 7'h3C, 1, 0, r_hit, r_instr, r_pk, r_lat);
    check("hit1e5_instr", r_instr, 32'h80AB01E5);
    check("hit1e5_packed", r_pk, 1);

    // Gapped fill of line 0x008 into bank 0, stalled mid-way, lookup held across it.
    ack_gap = 2;
    do_lookup("miss008", 10'h008, 7'h2B, 1, 7'h3C, 1, 0, r_hit, r_instr, r_pk, r_lat);
    check("miss008_hit", r_hit, 0);
    repeat (4) @(negedge clock);
    @(posedge clock); #1;
    enable_i = 1'b0;
    repeat (6) @(negedge clock);
    check("stall_req_held", mem_req_o, 1);
    @(posedge clock); #1;
    enable_i = 1'b1;
    do_lookup("held00a", 10'h00A, 7'h01, 1, 7'h3C, 1, 0, r_hit, r_instr, r_pk, r_lat);
    check("held00a_hit", r_hit, 1);
    check("held00a_instr", r_instr, 32'h00AB000A);
    check("held00a_after_update", ack_cyc - upd_cyc, 2);
    check("held_newtag", is_newtag_o, 7'h01);
    check("held_bank", is_bank_o, 0);
    ack_gap = 0;
    for (int i = 0; i < 8; i++) begin
      do_lookup("line008", 10'h008 + 10'(i), 7'h01, 1, 7'h3C, 1, 0, r_hit, r_instr, r_pk, r_lat);
      check("line008_instr", r_instr, mem_word(10'h008 + 10'(i)));
    end

    // Hit in bank 1 makes bank 0 LRU; equal tags then pick bank 0.
    do_lookup("hit1e0", 10'h1E0, 7'h01, 1, 7'h3C, 1, 0, r_hit, r_instr, r_pk, r_lat);
    check("hit1e0_instr", r_instr, 32'h00AB01E0);
    @(negedge clock);
    check("hit1e0_lru_no", is_lru_no, 1);
    do_lookup("both00b", 10'h00B, 7'h01, 1, 7'h01, 1, 0, r_hit, r_instr, r_pk, r_lat);
    check("both00b_instr", r_instr, 32'h80AB000B);
    check("both00b_packed", r_pk, 1);
    @(negedge clock);
    check("both00b_lru_no", is_lru_no, 0);

    // Reset during a fill stalled after 4 words.
    ack_limit = 4;
    do_lookup("miss2f0", 10'h2F0, 7'h01, 1, 7'h3C, 1, 0, r_hit, r_instr, r_pk, r_lat);
    check("miss2f0_hit", r_hit, 0);
    reached = 1'b0;
    for (int n = 0; n < 200 && !reached; n++) begin
      @(negedge clock);
      if (m_cnt == 4) reached = 1'b1;
    end
    check("four_words", reached, 1);
    repeat (3) @(negedge clock);
    check("partial_req", mem_req_o, 1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_req", mem_req_o, 0);
    check("abort_busy", is_busy_o, 0);
    check("abort_update", is_update_o, 0);
    check("abort_lru_no", is_lru_no, 1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    ack_limit = 8;
    n_upd = 0;
    repeat (10) begin
      @(negedge clock);
      if (is_update_o) n_upd++;
    end
    check("abort_no_update", n_upd, 0);

    // Post-reset lookups: one held off by enable_i, one normal.
    do_lookup("stall00d", 10'h00D, 7'h01, 1, 7'h00, 0, 3, r_hit, r_instr, r_pk, r_lat);
    check("stall00d_instr", r_instr, 32'h80AB000D);
    check("stall00d_lat", r_lat, 1);
    do_lookup("hit00c", 10'h00C, 7'h01, 1, 7'h00, 0, 0, r_hit, r_instr, r_pk, r_lat);
    check("hit00c_hit", r_hit, 1);
    check("hit00c_instr", r_instr, 32'h00AB000C);
    check("hit00c_lat", r_lat, 1);

    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
